spi_master: RTL



---
 rtl/spi_master_pkg.sv | 24 ++
 rtl/spi_master_tick.sv | 28 ++
 rtl/spi_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: register addresses, FSM states and
// control-register bit positions.
package spi_master_pkg;

  // Register addresses
  localparam logic SPI_CTRL = 1'b0;
  localparam logic SPI_DATA = 1'b1;

  // Transfer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // Control register layout: {DIV[3:0], BUSY, 0, SS[1:0]}
  localparam int CTRL_SS_LSB   = 0;
  localparam int CTRL_BUSY_BIT = 3;
  localparam int CTRL_DIV_LSB  = 4;

  // Bit counter value loaded at the start of a byte (MSB first)
  localparam logic [2:0] FIRST_BIT = 3'd7;

endpackage

// File: rtl/spi_master_tick.sv
// Reloadable SCK half-period down-counter. It holds at zero until reloaded,
// so done stays high for as long as the count is exhausted.
module spi_master_tick #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             done
);

  logic [DIV_W-1:0] cnt;

  // Reload on request, otherwise count down and stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master, MSB first, with a programmable SCK half-period
// and two software-controlled active-low slave selects.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       WR,
  input  logic       ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       BUSY,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic [1:0] nSS
);

  state_t           state;
  logic [1:0]       ss;
  logic [DIV_W-1:0] div;
  logic [7:0]       sr;
  logic             sample;
  logic [2:0]       bit_cnt;
  logic             sck_q;
  logic             busy_q;
  logic             tick_load;
  logic             tick_done;
  logic [3:0]       div_pad;
  logic [7:0]       ctrl_word;
  logic             data_wr;
  logic             ctrl_wr;

  assign data_wr = WR && (ADDR == SPI_DATA);
  assign ctrl_wr = WR && (ADDR == SPI_CTRL);

  // Half-period counter reloads when a transfer starts and on every phase change
  always_comb begin
    tick_load = 1'b0;
    case (state)
      IDLE:    tick_load = data_wr;
      default: tick_load = tick_done;
    endcase
  end

  spi_master_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (CLK),
    .rst_n(nRST),
    .load (tick_load),
    .div  (div),
    .done (tick_done)
  );

  // Control register: selects and divider, frozen while a byte is on the wire
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ss  <= 2'b00;
      div <= '0;
    end else if (ctrl_wr && !busy_q) begin
      ss  <= WDATA[CTRL_SS_LSB +: 2];
      div <= WDATA[CTRL_DIV_LSB +: DIV_W];
    end
  end

  // Transfer FSM: sample MISO as SCK rises, shift SR as SCK falls
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      sr      <= 8'h00;
      sample  <= 1'b0;
      bit_cnt <= 3'd0;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_wr) begin
            sr      <= WDATA;
            bit_cnt <= FIRST_BIT;
            state   <= LO;
            busy_q  <= 1'b1;
            sck_q   <= 1'b0;
          end
        end
        LO: begin
          if (tick_done) begin
            sample <= MISO;
            sck_q  <= 1'b1;
            state  <= HI;
          end
        end
        HI: begin
          if (tick_done) begin
            sr    <= {sr[6:0], sample};
            sck_q <= 1'b0;
            if (bit_cnt == 3'd0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              state   <= LO;
            end
          end
        end
        default: begin
          state  <= IDLE;
          sck_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-back view of the control register, divider zero-padded to 4 bits
  always_comb begin
    div_pad                        = 4'h0;
    div_pad[DIV_W-1:0]             = div;
    ctrl_word                      = 8'h00;
    ctrl_word[CTRL_DIV_LSB +: 4]   = div_pad;
    ctrl_word[CTRL_BUSY_BIT]       = busy_q;
    ctrl_word[CTRL_SS_LSB +: 2]    = ss;
  end

  // Register read mux
  always_comb begin
    RDATA = (ADDR == SPI_DATA) ? sr : ctrl_word;
  end

  assign BUSY = busy_q;
  assign SCK  = sck_q;
  assign MOSI = sr[7];
  assign nSS  = ~ss;

endmodule
